// File: rtl/fifo_sync_flex_if.sv
// Handshake bundle for fifo_sync_flex: producer/consumer requests on the master side, data and
// registered status on the slave (FIFO) side.
`timescale 1ns/1ps

interface fifo_sync_flex_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
);
  logic                  wr;
  logic [DATA_WIDTH-1:0] wdata;
  logic                  rd;
  logic [DATA_WIDTH-1:0] rdata;
  logic                  rd_valid;
  logic [ADDR_WIDTH:0]   fill;
  logic                  full;
  logic                  empty;
  logic                  almost_full;
  logic                  almost_empty;
  logic                  err_clr;
  logic                  overrun;
  logic                  underrun;

  modport master (
    output wr, wdata, rd, err_clr,
    input  rdata, rd_valid, fill, full, empty, almost_full, almost_empty, overrun, underrun
  );

  modport slave (
    input  wr, wdata, rd, err_clr,
    output rdata, rd_valid, fill, full, empty, almost_full, almost_empty, overrun, underrun
  );
endinterface

// File: rtl/fifo_sync_flex.sv
// Single-clock FIFO using all 2^ADDR_WIDTH entries, with registered thresholds and sticky errors.
// Define FIFO_SYNC_FLEX_FWFT_EN for first-word-fall-through reads; rst must be released synchronously to clk.
`timescale 1ns/1ps

module fifo_sync_flex #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4,
  parameter int AF_THRESH  = 12,
  parameter int AE_THRESH  = 2
) (
  input  logic            clk,
  input  logic            rst,
  fifo_sync_flex_if.slave bus
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] FILL_MAX = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0] AF_LEVEL = (ADDR_WIDTH+1)'(AF_THRESH);
  localparam logic [ADDR_WIDTH:0] AE_LEVEL = (ADDR_WIDTH+1)'(AE_THRESH);
  localparam logic [ADDR_WIDTH:0] PTR_ONE  = (ADDR_WIDTH+1)'(1);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_WIDTH:0]   wptr;
  logic [ADDR_WIDTH:0]   rptr;
  logic [ADDR_WIDTH:0]   fill_nxt;
  logic                  rd_ok;
  logic                  wr_ok;

  // A write into a full FIFO is still accepted when a read frees a slot in the same cycle.
  always_comb begin
    rd_ok    = bus.rd && !bus.empty;
    wr_ok    = bus.wr && (!bus.full || rd_ok);
    fill_nxt = bus.fill + (ADDR_WIDTH+1)'(wr_ok) - (ADDR_WIDTH+1)'(rd_ok);
  end

  // NOTE: storage has no reset; only pointers and fill define which words are valid, and
  // leaving the array unreset lets it map onto plain RAM.
  always_ff @(posedge clk) begin
    if (wr_ok) mem[wptr[ADDR_WIDTH-1:0]] <= bus.wdata;
  end

  // NOTE: all state updates use non-blocking assignments so every flag sees the pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr             <= '0;
      rptr             <= '0;
      bus.fill         <= '0;
      bus.empty        <= 1'b1;
      bus.full         <= 1'b0;
      bus.almost_full  <= 1'b0;
      bus.almost_empty <= 1'b1;
      bus.overrun      <= 1'b0;
      bus.underrun     <= 1'b0;
    end else begin
      if (wr_ok) wptr <= wptr + PTR_ONE;
      if (rd_ok) rptr <= rptr + PTR_ONE;
      bus.fill         <= fill_nxt;
      bus.empty        <= (fill_nxt == '0);
      bus.full         <= (fill_nxt == FILL_MAX);
      bus.almost_full  <= (fill_nxt >= AF_LEVEL);
      bus.almost_empty <= (fill_nxt <= AE_LEVEL);
      // A fresh reject outranks a clear arriving in the same cycle.
      bus.overrun      <= (bus.wr && !wr_ok) || (bus.overrun && !bus.err_clr);
      bus.underrun     <= (bus.rd && !rd_ok) || (bus.underrun && !bus.err_clr);
    end
  end

`ifdef FIFO_SYNC_FLEX_FWFT_EN
  // Head word is shown while non-empty; forced to zero otherwise so reset reads as zero.
  assign bus.rdata    = bus.empty ? '0 : mem[rptr[ADDR_WIDTH-1:0]];
  assign bus.rd_valid = !bus.empty;
`else
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.rdata    <= '0;
      bus.rd_valid <= 1'b0;
    end else begin
      bus.rd_valid <= rd_ok;
      if (rd_ok) bus.rdata <= mem[rptr[ADDR_WIDTH-1:0]];
    end
  end
`endif

endmodule

// File: tb/tb_fifo_sync_flex.sv
// Scoreboard bench for fifo_sync_flex; a queue model predicts data, fill, flags and sticky errors.
// Covers both read modes depending on FIFO_SYNC_FLEX_FWFT_EN.
`timescale 1ns/1ps

module tb_fifo_sync_flex;

  localparam int DW    = 8;
  localparam int AW    = 4;
  localparam int DEPTH = 1 << AW;
  localparam int AF    = 12;
  localparam int AE    = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;

  fifo_sync_flex_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  fifo_sync_flex #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .AF_THRESH(AF), .AE_THRESH(AE)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  int            n_cmp = 0;
  int            n_bad = 0;
  logic [DW-1:0] model_q [$];
  logic [DW-1:0] exp_q   [$];
  bit            exp_ovr = 1'b0;
  bit            exp_udr = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_status();
    check("fill",         32'(bus.fill),         32'(model_q.size()));
    check("empty",        32'(bus.empty),        32'(model_q.size() == 0));
    check("full",         32'(bus.full),         32'(model_q.size() == DEPTH));
    check("almost_full",  32'(bus.almost_full),  32'(model_q.size() >= AF));
    check("almost_empty", 32'(bus.almost_empty), 32'(model_q.size() <= AE));
    check("overrun",      32'(bus.overrun),      32'(exp_ovr));
    check("underrun",     32'(bus.underrun),     32'(exp_udr));
  endtask

  // One clock of stimulus: inputs applied 1ns after an edge, results sampled 1ns after the next.
  task automatic cycle(input logic w, input logic [DW-1:0] d, input logic r, input logic clr);
    bit rd_ok;
    bit wr_ok;
    rd_ok = r && (model_q.size() != 0);
    wr_ok = w && ((model_q.size() != DEPTH) || rd_ok);
    bus.wr      = w;
    bus.wdata   = d;
    bus.rd      = r;
    bus.err_clr = clr;
`ifndef FIFO_SYNC_FLEX_FWFT_EN
    if (rd_ok) exp_q.push_back(model_q[0]);
`endif
    if (rd_ok) void'(model_q.pop_front());
    if (wr_ok) model_q.push_back(d);
    exp_ovr = (w && !wr_ok) || (exp_ovr && !clr);
    exp_udr = (r && !rd_ok) || (exp_udr && !clr);
    @(posedge clk);
    #1;
    bus.wr      = 1'b0;
    bus.rd      = 1'b0;
    bus.err_clr = 1'b0;
`ifdef FIFO_SYNC_FLEX_FWFT_EN
    check("rd_valid", 32'(bus.rd_valid), 32'(model_q.size() != 0));
    if (model_q.size() != 0) check("fwft_head", 32'(bus.rdata), 32'(model_q[0]));
`else
    check("rd_valid", 32'(bus.rd_valid), 32'(rd_ok));
    if (bus.rd_valid && exp_q.size() != 0) check("rdata", 32'(bus.rdata), 32'(exp_q.pop_front()));
`endif
    check_status();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_fill"},     32'(bus.fill),         32'(0));
    check({tag, "_empty"},    32'(bus.empty),        32'(1));
    check({tag, "_full"},     32'(bus.full),         32'(0));
    check({tag, "_af"},       32'(bus.almost_full),  32'(0));
    check({tag, "_ae"},       32'(bus.almost_empty), 32'(1));
    check({tag, "_rdata"},    32'(bus.rdata),        32'(0));
    check({tag, "_rd_valid"}, 32'(bus.rd_valid),     32'(0));
    check({tag, "_overrun"},  32'(bus.overrun),      32'(0));
    check({tag, "_underrun"}, 32'(bus.underrun),     32'(0));
  endtask

  task automatic set_fill(input int target);
    while (model_q.size() < target) cycle(1'b1, 8'($urandom), 1'b0, 1'b0);
    while (model_q.size() > target) cycle(1'b0, '0, 1'b1, 1'b0);
  endtask

  task automatic run_wrap();
    int target;
    for (int i = 0; i < 40; i++) begin
      target = int'($urandom_range(0, DEPTH));
      set_fill(target);
      cycle(1'b1, 8'($urandom), 1'b1, 1'b0);
    end
    cycle(1'b0, '0, 1'b0, 1'b1);
  endtask

  task automatic mid_burst_reset();
    set_fill(7);
    bus.wr    = 1'b1;
    bus.wdata = 8'h77;
    #3;
    rst = 1'b1;
    #1;
    check_reset_outputs("rst_async");
    bus.wr = 1'b0;
    model_q.delete();
    exp_q.delete();
    exp_ovr = 1'b0;
    exp_udr = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    check_status();
    for (int i = 0; i < 3; i++) cycle(1'b1, 8'(8'hC0 + i), 1'b0, 1'b0);
    repeat (3) cycle(1'b0, '0, 1'b1, 1'b0);
  endtask

  initial begin
    bus.wr      = 1'b0;
    bus.wdata   = '0;
    bus.rd      = 1'b0;
    bus.err_clr = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("rst_init");
    rst = 1'b0;
    @(posedge clk);
    #1;
    check_status();

    for (int i = 1; i <= DEPTH; i++) cycle(1'b1, 8'(i), 1'b0, 1'b0);
    check("full_after_16", 32'(bus.full), 32'(1));

    cycle(1'b1, 8'h11, 1'b0, 1'b0);   // rejected write
    cycle(1'b1, 8'h12, 1'b0, 1'b1);   // clear loses to a new reject
    cycle(1'b0, '0,    1'b0, 1'b1);   // clear
    cycle(1'b1, 8'hAA, 1'b1, 1'b0);   // full: read and write together
    repeat (DEPTH) cycle(1'b0, '0, 1'b1, 1'b0);

    cycle(1'b0, '0,    1'b1, 1'b0);   // read on empty
    cycle(1'b0, '0,    1'b0, 1'b1);
    cycle(1'b1, 8'h55, 1'b1, 1'b0);   // empty: write taken, read rejected
    cycle(1'b0, '0,    1'b1, 1'b1);   // pop 0x55 while clearing

    run_wrap();
    mid_burst_reset();

    check("scoreboard_drained", 32'(exp_q.size()), 32'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

endmodule
